jtag_tap_confreg: RTL and testbench



---
 rtl/jtag_tap_confreg_if.sv | 28 ++
 rtl/jtag_tap_confreg.sv | 222 ++++++++++++++++++++++
 tb/tb_jtag_tap_confreg.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_confreg_if.sv
// JTAG pin bundle between a host-side driver and the TAP responder.
// The host drives TCK/TMS/TDI/TRST and observes TDO and its output enable.
interface jtag_tap_confreg_if;
    logic tck;
    logic trst_n;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;

    modport master (
        output tck,
        output trst_n,
        output tms,
        output tdi,
        input  tdo,
        input  tdo_en
    );

    modport slave (
        input  tck,
        input  trst_n,
        input  tms,
        input  tdi,
        output tdo,
        output tdo_en
    );
endinterface

// File: rtl/jtag_tap_confreg.sv
// Oversampled JTAG TAP with IDCODE, BYPASS and a configuration register.
// Define JTAG_TAP_CONF_READBACK_EN to capture conf_reg_o on a conf DR scan.
module jtag_tap_confreg #(
    parameter logic [31:0]         IDCODE     = 32'h1000_1DB3,
    parameter int unsigned         IR_WIDTH   = 5,
    parameter int unsigned         CONF_WIDTH = 9,
    parameter logic [IR_WIDTH-1:0] INSTR_CONF = 5'b00110
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    jtag_tap_confreg_if.slave     jtag,
    output logic [CONF_WIDTH-1:0] conf_reg_o,
    output logic                  conf_upd_o
);

    localparam int unsigned DR_W =
        (CONF_WIDTH > 32) ? CONF_WIDTH : 32;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(5);

    typedef enum logic [3:0] {
        TLR,
        RTI,
        SEL_DR,
        CAP_DR,
        SH_DR,
        EX1_DR,
        PAUSE_DR,
        EX2_DR,
        UPD_DR,
        SEL_IR,
        CAP_IR,
        SH_IR,
        EX1_IR,
        PAUSE_IR,
        EX2_IR,
        UPD_IR
    } tap_state_e;

    logic [1:0] tck_s_q;
    logic [1:0] tms_s_q;
    logic [1:0] tdi_s_q;
    logic [1:0] trst_s_q;
    logic       tck_dly_q;

    logic tck_rise;
    logic tck_fall;
    logic tms_s;
    logic tdi_s;
    logic trst_s;

    tap_state_e state_q, state_d;

    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic [IR_WIDTH-1:0]   ir_sr_q, ir_sr_d;
    logic [DR_W-1:0]       dr_sr_q, dr_sr_d;
    logic [CONF_WIDTH-1:0] conf_q, conf_d;
    logic                  upd_q, upd_d;
    logic                  tdo_q, tdo_d;
    logic                  tdo_en_q, tdo_en_d;

    logic [DR_W-1:0] dr_cap;
    logic [DR_W-1:0] dr_shift;
    logic            sel_idcode;
    logic            sel_conf;

    // Two-flop synchronizers; TCK gets one extra flop for edge detect.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tck_s_q   <= '0;
            tms_s_q   <= '0;
            tdi_s_q   <= '0;
            trst_s_q  <= '0;
            tck_dly_q <= 1'b0;
        end else begin
            tck_s_q   <= {tck_s_q[0], jtag.tck};
            tms_s_q   <= {tms_s_q[0], jtag.tms};
            tdi_s_q   <= {tdi_s_q[0], jtag.tdi};
            trst_s_q  <= {trst_s_q[0], jtag.trst_n};
            tck_dly_q <= tck_s_q[1];
        end
    end

    assign tck_rise = tck_s_q[1] & ~tck_dly_q;
    assign tck_fall = ~tck_s_q[1] & tck_dly_q;
    assign tms_s    = tms_s_q[1];
    assign tdi_s    = tdi_s_q[1];
    assign trst_s   = trst_s_q[1];

    function automatic tap_state_e tap_next(
        input tap_state_e s,
        input logic       tms
    );
        case (s)
            TLR:      tap_next = tms ? TLR    : RTI;
            RTI:      tap_next = tms ? SEL_DR : RTI;
            SEL_DR:   tap_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:   tap_next = tms ? EX1_DR : SH_DR;
            SH_DR:    tap_next = tms ? EX1_DR : SH_DR;
            EX1_DR:   tap_next = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: tap_next = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   tap_next = tms ? UPD_DR : SH_DR;
            UPD_DR:   tap_next = tms ? SEL_DR : RTI;
            SEL_IR:   tap_next = tms ? TLR    : CAP_IR;
            CAP_IR:   tap_next = tms ? EX1_IR : SH_IR;
            SH_IR:    tap_next = tms ? EX1_IR : SH_IR;
            EX1_IR:   tap_next = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: tap_next = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   tap_next = tms ? UPD_IR : SH_IR;
            UPD_IR:   tap_next = tms ? SEL_DR : RTI;
            default:  tap_next = TLR;
        endcase
    endfunction

    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_conf   = (ir_q == INSTR_CONF);

    // Chain selected by IR; anything undefined falls back to bypass.
    always_comb begin
        dr_cap   = '0;
        dr_shift = dr_sr_q >> 1;
        unique case (1'b1)
            sel_idcode: begin
                dr_cap       = DR_W'(IDCODE);
                dr_shift[31] = tdi_s;
            end
            sel_conf: begin
`ifdef JTAG_TAP_CONF_READBACK_EN
                dr_cap = DR_W'(conf_q);
`else
                dr_cap = '0;
`endif
                dr_shift[CONF_WIDTH-1] = tdi_s;
            end
            default: begin
                dr_cap      = '0;
                dr_shift    = '0;
                dr_shift[0] = tdi_s;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ir_sr_d = ir_sr_q;
        dr_sr_d = dr_sr_q;
        conf_d  = conf_q;
        upd_d   = 1'b0;
        tdo_d   = tdo_q;

        if (tck_rise) begin
            state_d = tap_next(state_q, tms_s);
            case (state_q)
                CAP_IR:  ir_sr_d = IR_CAPTURE;
                SH_IR:   ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
                CAP_DR:  dr_sr_d = dr_cap;
                SH_DR:   dr_sr_d = dr_shift;
                default: ;
            endcase
            if (state_d == UPD_IR) begin
                ir_d = ir_sr_q;
            end
            if (state_d == UPD_DR && sel_conf) begin
                conf_d = dr_sr_q[CONF_WIDTH-1:0];
                upd_d  = 1'b1;
            end
        end

        if (tck_fall) begin
            case (state_q)
                SH_IR:   tdo_d = ir_sr_q[0];
                SH_DR:   tdo_d = dr_sr_q[0];
                default: ;
            endcase
        end

        // TRST abandons any scan in flight without touching conf.
        if (!trst_s) begin
            state_d = TLR;
            conf_d  = conf_q;
            upd_d   = 1'b0;
        end

        if (state_d == TLR) begin
            ir_d    = IR_IDCODE;
            ir_sr_d = '0;
            dr_sr_d = '0;
        end

        tdo_en_d = (state_d == SH_DR) || (state_d == SH_IR);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= TLR;
            ir_q     <= IR_IDCODE;
            ir_sr_q  <= '0;
            dr_sr_q  <= '0;
            conf_q   <= '0;
            upd_q    <= 1'b0;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            dr_sr_q  <= dr_sr_d;
            conf_q   <= conf_d;
            upd_q    <= upd_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign jtag.tdo    = tdo_q;
    assign jtag.tdo_en = tdo_en_q;
    assign conf_reg_o  = conf_q;
    assign conf_upd_o  = upd_q;

endmodule

// File: tb/tb_jtag_tap_confreg.sv
// Directed bench for jtag_tap_confreg: bit-banged TAP scans on the pins.
// Honours JTAG_TAP_CONF_READBACK_EN for the expected readback value.
module tb_jtag_tap_confreg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] conf_reg;
    logic       conf_upd;

    int n_cmp  = 0;
    int n_fail = 0;
    int upd_cnt = 0;
    int u0;

    logic        last_tdo;
    logic [31:0] d;

`ifdef JTAG_TAP_CONF_READBACK_EN
    localparam logic [8:0] EXP_RB = 9'h002;
`else
    localparam logic [8:0] EXP_RB = 9'h000;
`endif

    jtag_tap_confreg_if jif ();

    jtag_tap_confreg dut (
        .clk_i      (clk),
        .rst_n      (rst_n),
        .jtag       (jif.slave),
        .conf_reg_o (conf_reg),
        .conf_upd_o (conf_upd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (conf_upd === 1'b1) upd_cnt <= upd_cnt + 1;
    end

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t, input logic di);
        jif.tms = t;
        jif.tdi = di;
        #40;
        jif.tck = 1'b1;
        #40;
        jif.tck = 1'b0;
        #50;
        last_tdo = jif.tdo;
    endtask

    // Scan from RTI back to RTI; dout[i] is TDO seen before shift i.
    task automatic scan(
        input  bit          ir,
        input  int          n,
        input  logic [31:0] din,
        output logic [31:0] dout
    );
        step(1'b1, 1'b0);
        if (ir) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("tdo_en_in_shift", {31'b0, jif.tdo_en}, 32'd1);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = last_tdo;
            step(i == n - 1, din[i]);
        end
        chk("tdo_en_after_shift", {31'b0, jif.tdo_en}, 32'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        jif.tck    = 1'b0;
        jif.trst_n = 1'b1;
        jif.tms    = 1'b1;
        jif.tdi    = 1'b0;
        last_tdo   = 1'b0;
        #22;
        chk("rst_tdo", {31'b0, jif.tdo}, 32'd0);
        chk("rst_tdo_en", {31'b0, jif.tdo_en}, 32'd0);
        chk("rst_conf", {23'b0, conf_reg}, 32'd0);
        chk("rst_upd", {31'b0, conf_upd}, 32'd0);
        rst_n = 1'b1;
        #20;

        jif.trst_n = 1'b0;
        #60;
        jif.trst_n = 1'b1;
        #40;
        step(1'b0, 1'b0);

        scan(1'b1, 5, 32'h01, d);
        chk("capture_ir", {27'b0, d[4:0]}, 32'h05);
        scan(1'b0, 32, 32'h0, d);
        chk("idcode", d, 32'h1000_1DB3);

        scan(1'b1, 5, 32'h1F, d);
        scan(1'b0, 9, 32'h0A5, d);
        chk("bypass", {23'b0, d[8:0]}, 32'h14A);

        scan(1'b1, 5, 32'h0A, d);
        scan(1'b0, 9, 32'h0A5, d);
        chk("undef_bypass", {23'b0, d[8:0]}, 32'h14A);

        scan(1'b1, 5, 32'h06, d);
        u0 = upd_cnt;
        scan(1'b0, 9, 32'h002, d);
        chk("conf_write_tdo", {23'b0, d[8:0]}, 32'h0);
        chk("conf_write", {23'b0, conf_reg}, 32'h002);
        chk("conf_upd_pulse", upd_cnt - u0, 32'd1);

        u0 = upd_cnt;
        scan(1'b0, 9, 32'h000, d);
        chk("readback", {23'b0, d[8:0]}, {23'b0, EXP_RB});
        chk("conf_clear", {23'b0, conf_reg}, 32'h0);
        chk("conf_upd_pulse2", upd_cnt - u0, 32'd1);

        scan(1'b0, 9, 32'h1A5, d);
        chk("conf_1a5", {23'b0, conf_reg}, 32'h1A5);

        u0 = upd_cnt;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        jif.trst_n = 1'b0;
        #60;
        chk("trst_tdo_en", {31'b0, jif.tdo_en}, 32'd0);
        jif.trst_n = 1'b1;
        #40;
        chk("trst_conf_kept", {23'b0, conf_reg}, 32'h1A5);
        chk("trst_no_upd", upd_cnt - u0, 32'd0);
        step(1'b0, 1'b0);
        scan(1'b0, 32, 32'h0, d);
        chk("trst_idcode", d, 32'h1000_1DB3);

        scan(1'b1, 5, 32'h06, d);
        scan(1'b0, 9, 32'h1FF, d);
        chk("conf_1ff", {23'b0, conf_reg}, 32'h1FF);
        scan(1'b1, 5, 32'h1F, d);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("pre_rst_tdo", {31'b0, jif.tdo}, 32'd1);
        chk("pre_rst_tdo_en", {31'b0, jif.tdo_en}, 32'd1);
        #4;
        rst_n = 1'b0;
        #1;
        chk("arst_conf", {23'b0, conf_reg}, 32'h0);
        chk("arst_tdo", {31'b0, jif.tdo}, 32'd0);
        chk("arst_tdo_en", {31'b0, jif.tdo_en}, 32'd0);
        chk("arst_upd", {31'b0, conf_upd}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
